// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   DEF_ADDR_W / DEF_DATA_W : default address / word widths
//   MAX_WORDS               : largest legal load length at the default width
//   loadState_t             : loader FSM state encoding
package imem_loader_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;
    localparam int MAX_WORDS  = 1 << DEF_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WRITE,
        CHK,
        DONE,
        ERR
    } loadState_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: control, byte-stream and memory-write signals of the loader.
//   slave  : loader side (takes start/length/bytes, drives ready/write/status)
//   master : host side (drives start/length/bytes, observes ready/write/status)
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              iStart;
    logic [ADDR_W:0]   iLength;
    logic [7:0]        iByte;
    logic              iByteValid;
    logic              oByteReady;
    logic              oWrEnable;
    logic [ADDR_W-1:0] oWrAddr;
    logic [DATA_W-1:0] oWrData;
    logic              oCpuReset;
    logic              oDone;
    logic              oError;

    modport slave (
        input  iStart, iLength, iByte, iByteValid,
        output oByteReady, oWrEnable, oWrAddr, oWrData, oCpuReset, oDone, oError
    );

    modport master (
        output iStart, iLength, iByte, iByteValid,
        input  oByteReady, oWrEnable, oWrAddr, oWrData, oCpuReset, oDone, oError
    );

endinterface

// File: rtl/imem_loader_chk.sv
// loader_chk: 8-bit running XOR checksum of the program bytes.
//   clk, rst : clock, async active-high reset
//   clr      : zero the accumulator (wins over en)
//   en       : XOR din into the accumulator
//   acc      : current checksum
module loader_chk (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a program as a big-endian byte stream, writes it into
// instruction memory one word per three cycles, then verifies a trailing XOR
// checksum byte. The processor is held in reset until a load ends in DONE.
//   clk, Reset : clock, async active-high reset
//   bus        : imem_loader_if.slave (start/length, byte stream, write port,
//                cpu reset and done/error status; all outputs registered)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic         clk,
    input  logic         Reset,
    imem_loader_if.slave bus
);

    // 2^ADDR_W in ADDR_W+1 bits: the largest legal length
    localparam logic [ADDR_W:0] maxWords = {1'b1, {ADDR_W{1'b0}}};

    loadState_t      state, stateNext;
    logic [ADDR_W:0] wordCnt, wordCntNext;
    logic [ADDR_W:0] lenReg, lenRegNext;
    logic [ADDR_W:0] cntInc;
    logic [7:0]      hiByte, hiByteNext;
    logic [7:0]      acc;
    logic            accClr, accEn;
    logic            byteTake;
    logic            lenOk;

    // oByteReady is a registered decode of state, so it equals "state in HI/LO/CHK"
    assign byteTake = bus.iByteValid & bus.oByteReady;
    assign cntInc   = wordCnt + 1'b1;
    assign lenOk    = (bus.iLength != '0) && (bus.iLength <= maxWords);

    loader_chk uChk (
        .clk (clk),
        .rst (Reset),
        .clr (accClr),
        .en  (accEn),
        .din (bus.iByte),
        .acc (acc)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        wordCntNext = wordCnt;
        lenRegNext  = lenReg;
        hiByteNext  = hiByte;
        accClr      = 1'b0;
        accEn       = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (bus.iStart) begin
                    if (lenOk) begin
                        stateNext   = HI;
                        wordCntNext = '0;
                        lenRegNext  = bus.iLength;
                        accClr      = 1'b1;
                    end else begin
                        stateNext = ERR;
                    end
                end
            end
            HI: begin
                if (byteTake) begin
                    hiByteNext = bus.iByte;
                    accEn      = 1'b1;
                    stateNext  = LO;
                end
            end
            LO: begin
                if (byteTake) begin
                    accEn     = 1'b1;
                    stateNext = WRITE;
                end
            end
            WRITE: begin
                // counter is one bit wider than the address so a full
                // 2^ADDR_W load compares equal instead of wrapping to zero
                wordCntNext = cntInc;
                stateNext   = (cntInc == lenReg) ? CHK : HI;
            end
            CHK: begin
                if (byteTake) begin
                    stateNext = (bus.iByte == acc) ? DONE : ERR;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are flopped from the next-state decode so they line up with state.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wordCnt        <= '0;
            lenReg         <= '0;
            hiByte         <= '0;
            bus.oByteReady <= 1'b0;
            bus.oWrEnable  <= 1'b0;
            bus.oWrAddr    <= '0;
            bus.oWrData    <= '0;
            bus.oCpuReset  <= 1'b1;
            bus.oDone      <= 1'b0;
            bus.oError     <= 1'b0;
        end else begin
            wordCnt        <= wordCntNext;
            lenReg         <= lenRegNext;
            hiByte         <= hiByteNext;
            bus.oByteReady <= (stateNext == HI) || (stateNext == LO) || (stateNext == CHK);
            bus.oWrEnable  <= (stateNext == WRITE);
            if (state == LO && byteTake) begin
                bus.oWrAddr <= wordCnt[ADDR_W-1:0];
                bus.oWrData <= DATA_W'({hiByte, bus.iByte});
            end
            bus.oCpuReset  <= (stateNext != DONE);
            bus.oDone      <= (stateNext == DONE);
            bus.oError     <= (stateNext == ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [AW-1:0] lastWrAddr = '0;
    wr_t  expQ[$];

    imem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // monitor: every write strobe must match the next expected write
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!Reset && bus.oWrEnable === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected write: addr 0x%0h data 0x%0h", bus.oWrAddr, bus.oWrData);
            end else begin
                e = expQ.pop_front();
                if (bus.oWrAddr !== e.addr || bus.oWrData !== e.data) begin
                    errors++;
                    $display("FAIL write: got [0x%0h]=0x%0h expected [0x%0h]=0x%0h",
                             bus.oWrAddr, bus.oWrData, e.addr, e.data);
                end
            end
            lastWrAddr = bus.oWrAddr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chkStatus(input string name, input bit expDone, input bit expErr, input bit expCpuRst);
        chk({name, " oDone"}, 32'(bus.oDone), 32'(expDone));
        chk({name, " oError"}, 32'(bus.oError), 32'(expErr));
        chk({name, " oCpuReset"}, 32'(bus.oCpuReset), 32'(expCpuRst));
    endtask

    task automatic doReset();
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic startLoad(input int len);
        bus.iStart  = 1'b1;
        bus.iLength = (AW+1)'(len);
        @(posedge clk);
        #1;
        bus.iStart  = 1'b0;
    endtask

    // Present bytes in order; a byte counts as sent only on a valid&ready edge.
    // noisy: random iStart pulses with junk lengths, which a busy loader ignores.
    task automatic sendBytes(input logic [7:0] q[$], input int gapPct, input bit noisy, input string name);
        int   idx = 0;
        int   guard = 0;
        logic took;
        while (idx < q.size()) begin
            if (guard > 20000) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: %0d of %0d bytes taken", name, idx, q.size());
                break;
            end
            bus.iByteValid = ($urandom_range(99) >= gapPct);
            bus.iByte      = bus.iByteValid ? q[idx] : 8'($urandom);
            bus.iStart     = noisy && ($urandom_range(9) == 0);
            bus.iLength    = (AW+1)'($urandom);
            took = bus.iByteValid && bus.oByteReady;
            @(posedge clk);
            #1;
            if (took) idx++;
            guard++;
        end
        bus.iByteValid = 1'b0;
        bus.iStart     = 1'b0;
    endtask

    // Reference: word i goes to address i as {hi,lo}; checksum = XOR of all data bytes.
    task automatic runLoad(input logic [15:0] w[$], input bit badSum, input int gapPct,
                           input bit noisy, input string name, output int cycles);
        logic [7:0] bytesQ[$];
        logic [7:0] sum = 8'h00;
        int t0;
        bytesQ = {};
        foreach (w[i]) begin
            bytesQ.push_back(w[i][15:8]);
            bytesQ.push_back(w[i][7:0]);
            sum = sum ^ w[i][15:8] ^ w[i][7:0];
            expQ.push_back('{addr: AW'(i), data: w[i]});
        end
        bytesQ.push_back(badSum ? (sum ^ 8'h01) : sum);
        startLoad(w.size());
        t0 = cyc;
        sendBytes(bytesQ, gapPct, noisy, name);
        cycles = cyc - t0;
        chk({name, " writes drained"}, 32'(expQ.size()), 32'd0);
        chkStatus(name, !badSum, badSum, badSum);
        expQ = {};
    endtask

    initial begin : stim
        logic [15:0] w[$];
        logic [7:0]  part[$];
        int cycles;
        int n;
        bit bad;
        bus.iStart = 1'b0;
        bus.iLength = '0;
        bus.iByte = '0;
        bus.iByteValid = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chkStatus("reset", 1'b0, 1'b0, 1'b1);
        chk("reset oByteReady", 32'(bus.oByteReady), 32'd0);
        chk("reset oWrEnable", 32'(bus.oWrEnable), 32'd0);
        chk("reset oWrAddr", 32'(bus.oWrAddr), 32'd0);
        chk("reset oWrData", 32'(bus.oWrData), 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        @(posedge clk);
        #1;

        // directed good / bad checksum (12^34^AB^CD = 0x40)
        w = {16'h1234, 16'hABCD};
        runLoad(w, 1'b0, 0, 1'b0, "good2", cycles);
        runLoad(w, 1'b1, 0, 1'b0, "badsum2", cycles);

        // illegal lengths
        doReset();
        chk("len0 pre oError", 32'(bus.oError), 32'd0);
        startLoad(0);
        chkStatus("len0", 1'b0, 1'b1, 1'b1);
        chk("len0 oByteReady", 32'(bus.oByteReady), 32'd0);
        doReset();
        startLoad(MAX_WORDS + 1);
        chkStatus("len1025", 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("len1025 still err", 32'(bus.oError), 32'd1);

        // 4-word loads: stall-free then random valid gaps, same expectations
        for (int k = 0; k < 3; k++) begin
            w = {};
            repeat (4) w.push_back(16'($urandom));
            runLoad(w, 1'b0, 0, 1'b0, "w4 nogap", cycles);
            chk("w4 nogap cycles", 32'(cycles), 32'd13);
            runLoad(w, 1'b0, 50, 1'b1, "w4 gaps", cycles);
        end

        // random short loads, random checksum validity
        for (int k = 0; k < 5; k++) begin
            n = $urandom_range(6, 1);
            bad = 1'($urandom_range(1));
            w = {};
            repeat (n) w.push_back(16'($urandom));
            runLoad(w, bad, 30, 1'b1, "rand", cycles);
        end

        // reset after the 3rd byte, then a full reload
        w = {16'hBEEF, 16'h0F0F};
        startLoad(2);
        expQ.push_back('{addr: AW'(0), data: 16'hBEEF});
        part = {8'hBE, 8'hEF, 8'h0F};
        sendBytes(part, 0, 1'b0, "partial");
        chk("partial write seen", 32'(expQ.size()), 32'd0);
        #2;
        Reset = 1'b1;
        #1;
        chk("midreset oCpuReset", 32'(bus.oCpuReset), 32'd1);
        chk("midreset oByteReady", 32'(bus.oByteReady), 32'd0);
        chk("midreset oWrEnable", 32'(bus.oWrEnable), 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        @(posedge clk);
        #1;
        runLoad(w, 1'b0, 20, 1'b0, "reload", cycles);

        // full-size load
        w = {};
        repeat (MAX_WORDS) w.push_back(16'($urandom));
        runLoad(w, 1'b0, 0, 1'b0, "full", cycles);
        chk("full cycles", 32'(cycles), 32'(3 * MAX_WORDS + 1));
        chk("full last addr", 32'(lastWrAddr), 32'h3FF);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory address width.
REQ-002 Parameter DATA_W, default 16, instruction word width; fixed at two bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 iStart  input  1  single-cycle request to begin a load.
REQ-006 iLength  input  ADDR_W+1  word count to load, sampled on accepted iStart.
REQ-007 iByte  input  8  incoming program byte.
REQ-008 iByteValid  input  1  iByte valid.
REQ-009 oByteReady  output  1  loader accepts iByte this cycle.
REQ-010 oWrEnable  output  1  instruction-memory write strobe.
REQ-011 oWrAddr  output  ADDR_W  instruction-memory write address.
REQ-012 oWrData  output  DATA_W  instruction word to write.
REQ-013 oCpuReset  output  1  drives processor Reset; high holds the core in reset.
REQ-014 oDone  output  1  load completed with good checksum.
REQ-015 oError  output  1  load rejected: bad length or checksum mismatch.

Function
REQ-016 FSM states IDLE, HI, LO, WRITE, CHK, DONE, ERR; all outputs registered.
REQ-017 Byte transfer occurs only on a cycle with iByteValid=1 and oByteReady=1.
REQ-018 oByteReady=1 only in HI, LO, CHK; 0 in all other states.
REQ-019 IDLE/DONE/ERR + iStart: iLength in 1..2^ADDR_W -> HI, word counter=0, XOR accumulator=0, oCpuReset=1, oDone=0, oError=0.
REQ-020 IDLE/DONE/ERR + iStart with iLength=0 or >2^ADDR_W -> ERR next cycle, oCpuReset=1.
REQ-021 iStart in HI, LO, WRITE, CHK is ignored.
REQ-022 HI: accepted byte stored as word[15:8] -> LO; LO: accepted byte stored as word[7:0] -> WRITE.
REQ-023 Each accepted data byte XORed into the 8-bit accumulator.
REQ-024 WRITE lasts exactly one cycle: oWrEnable=1, oWrAddr=counter, oWrData={hi,lo}; oWrEnable=0 in every other state.
REQ-025 After WRITE, counter increments; counter==length -> CHK, else -> HI.
REQ-026 Counter of width ADDR_W+1; a full load of 2^ADDR_W words does not wrap before the compare; oWrAddr takes the low ADDR_W bits.
REQ-027 CHK: accepted byte equal to accumulator -> DONE, else -> ERR.
REQ-028 DONE: oCpuReset=0, oDone=1, held until next iStart or Reset.
REQ-029 ERR: oCpuReset=1, oError=1, held until next iStart or Reset.
REQ-030 Minimum throughput: 3 cycles per word with iByteValid held high.

Reset
REQ-031 Reset asserted at any time, including mid-load, forces IDLE within the same cycle, asynchronously.
REQ-032 Reset values: oCpuReset=1, oByteReady=0, oWrEnable=0, oWrAddr=0, oWrData=0, oDone=0, oError=0, counter=0, accumulator=0.
REQ-033 A partially written image is not cleared; the core stays in reset until a complete load reaches DONE.

Structure
REQ-034 Shared package holds the state enumeration, default ADDR_W/DATA_W, and constant MAX_WORDS = 2^ADDR_W.
REQ-035 One sub-module, loader_chk: 8-bit XOR accumulator with clear and enable inputs.

Verification
REQ-036 iStart, iLength=2, bytes 12 34 AB CD, checksum 0x40 -> writes [0]=0x1234, [1]=0xABCD, then oDone=1, oCpuReset=0.
REQ-037 Same stream with checksum 0x41 -> two writes occur, then oError=1, oCpuReset stays 1.
REQ-038 iStart with iLength=0, then with iLength=1025 -> ERR one cycle later each time, no oWrEnable pulse.
REQ-039 iByteValid toggled randomly during a 4-word load -> bytes taken only when valid and ready; write data and addresses are identical to the stall-free run.
REQ-040 Reset pulsed after the 3rd byte of a load -> IDLE, oCpuReset=1; a new iStart plus a full load -> DONE.
REQ-041 iLength=1024, continuous valid -> last write has oWrAddr=0x3FF, DONE reached 3072 cycles after entering HI, plus the checksum cycle.
